ntt_addr_seq: RTL

//  Upstream sequencer for the 128-entry NTT address ROM (4 x 7-bit lanes per word).
//  On start, walks the ROM index 0..127 across 4 stages of 32 words (stage = idx[6:5]).

---
 rtl/ntt_pkg.sv | 19 +
 rtl/ntt_gap_cnt.sv | 28 ++
 rtl/ntt_addr_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT address sequencer.
// Pure declarations; no logic, no latency, no flow control.
// ROM geometry: 128 words walked as 4 stages of 32.
package ntt_pkg;

    localparam int NTT_ADDR_W = 7;
    localparam int NTT_STG_W  = 2;
    localparam int NTT_GAP_W  = 4;
    localparam int NTT_WORDS  = 2 ** NTT_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/ntt_gap_cnt.sv
// Loadable down-counter timing the inter-stage bubble; zero flag is combinational.
// Load takes effect next cycle; counts down by one per cycle and parks at zero.
// No backpressure: the counter runs regardless of downstream readiness.
module ntt_gap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ntt_addr_seq.sv
// NTT ROM index sequencer with inter-stage bubbles; NTT_SEQ_INTT_EN adds inverse walk.
// Latency: start -> first rom_addr next cycle; data_vld/last/stg trail an issue by 1 cycle.
// Backpressure: rdy=0 in RUN holds rom_addr and injects a vld bubble; GAP ignores rdy.
module ntt_addr_seq
    import ntt_pkg::*;
#(
    parameter int ADDR_W = NTT_ADDR_W,
    parameter int STG_W  = NTT_STG_W,
    parameter int GAP_W  = NTT_GAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GAP_W-1:0]  gap_cfg,
`ifdef NTT_SEQ_INTT_EN
    input  logic              inv,
`endif
    input  logic              rdy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              data_vld,
    output logic              data_last,
    output logic [STG_W-1:0]  data_stg,
    output logic              busy,
    output logic              done
);

    localparam int LO_W = ADDR_W - STG_W;
    localparam logic [ADDR_W-1:0] IDX_MAX = '1;
    localparam logic [LO_W-1:0]   LO_MAX  = '1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_nxt, idx_first, idx_end;
    logic [LO_W-1:0]   lo_end;
    logic [STG_W-1:0]  idx_stg;
    logic [GAP_W-1:0]  gap_q;
    logic              accept, issue, at_end, stg_end, gap_load, gap_zero;

`ifdef NTT_SEQ_INTT_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= inv;
        end
    end

    // Inverse walk mirrors the index; stage numbering stays 0..3 in walk order.
    assign idx_first = inv ? IDX_MAX : '0;
    assign idx_end   = inv_q ? '0 : IDX_MAX;
    assign lo_end    = inv_q ? '0 : LO_MAX;
    assign idx_nxt   = inv_q ? idx_q - 1'b1 : idx_q + 1'b1;
    assign idx_stg   = inv_q ? ~idx_q[ADDR_W-1 -: STG_W] : idx_q[ADDR_W-1 -: STG_W];
`else
    assign idx_first = '0;
    assign idx_end   = IDX_MAX;
    assign lo_end    = LO_MAX;
    assign idx_nxt   = idx_q + 1'b1;
    assign idx_stg   = idx_q[ADDR_W-1 -: STG_W];
`endif

    assign accept   = (state_q == ST_IDLE) && start;
    assign issue    = (state_q == ST_RUN) && rdy;
    assign at_end   = (idx_q == idx_end);
    assign stg_end  = issue && (idx_q[LO_W-1:0] == lo_end) && !at_end;
    assign gap_load = stg_end && (gap_q != '0);

    ntt_gap_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_q - 1'b1),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (issue && at_end) state_d = ST_FLUSH;
                else if (gap_load)   state_d = ST_GAP;
            end
            ST_GAP:   if (gap_zero) state_d = ST_RUN;
            ST_FLUSH: if (data_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            gap_q <= '0;
        end else if (accept) begin
            idx_q <= idx_first;
            gap_q <= gap_cfg;
        end else if (issue && !at_end) begin
            idx_q <= idx_nxt;
        end
    end

    // One register stage matches the ROM's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_vld  <= 1'b0;
            data_last <= 1'b0;
            data_stg  <= '0;
        end else begin
            data_vld  <= issue;
            data_last <= issue && at_end;
            data_stg  <= idx_stg;
        end
    end

    assign rom_addr = idx_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_GAP) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);

endmodule
